// File: rtl/basket_pkg.sv
// Shared types and constants for the shopping basket controller:
// state encoding, error codes, slot layout and the product price table.
package basket_pkg;

  localparam int PRODUCT_COUNT = 12;

  // Unit price (8 bits) for product IDs 0..11.
  localparam logic [7:0] PRICE_TABLE [PRODUCT_COUNT] = '{
    8'd12, 8'd25, 8'd40, 8'd55, 8'd15, 8'd30,
    8'd80, 8'd120, 8'd5, 8'd60, 8'd200, 8'd255
  };

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_FULL    = 3'd1,
    ERR_EMPTY   = 3'd2,
    ERR_QTY_SAT = 3'd3,
    ERR_BAD_ARG = 3'd4,
    ERR_BUSY    = 3'd5
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_WRITE,
    ST_COMPACT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] id;
    logic [2:0] qty;
  } slot_t;

endpackage

// File: rtl/product_price_rom.sv
// Combinational product price lookup; IDs outside the catalogue price at 0.
module product_price_rom
  import basket_pkg::*;
(
  input  logic [3:0] id,
  output logic [7:0] price
);

  always_comb begin
    price = '0;
    if (id < 4'(PRODUCT_COUNT)) price = PRICE_TABLE[id];
  end

endmodule

// File: rtl/basket_controller.sv
// Customer basket: merges/appends adds, compacts on cancel, keeps a running
// total price and exposes a combinational read port for the display.
module basket_controller
  import basket_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int MAX_QTY   = 7,
  parameter int TOTAL_W   = 16,
  localparam int IDX_W    = $clog2(NUM_SLOTS),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               Add_Req,
  input  logic [3:0]         Add_ProductID,
  input  logic [2:0]         Add_Quantity,
  input  logic               Cancel_Req,
  input  logic               Clear_Req,
  input  logic               Cursor_Up,
  input  logic               Cursor_Down,
  input  logic [IDX_W-1:0]   Read_Index,
  output logic [3:0]         Read_ProductID,
  output logic [2:0]         Read_Quantity,
  output logic               Read_Valid,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [2:0]         Error_Code,
  output logic [CNT_W-1:0]   Item_Count,
  output logic [IDX_W-1:0]   Cursor,
  output logic [TOTAL_W-1:0] Total_Price
);

  state_t             state;
  slot_t              slots [NUM_SLOTS];
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   cursor;
  logic [TOTAL_W-1:0] total;
  logic               busy, done, error;
  err_t               err_code;
  logic [3:0]         add_id;
  logic [2:0]         add_qty;
  logic               add_match;
  logic [CNT_W-1:0]   idx;

  logic [CNT_W-1:0]   srch_idx;
  logic [3:0]         srch_id;
  logic               at_end, hit, any_req, add_bad, wr_sat;
  logic [IDX_W-1:0]   wr_slot;
  logic [2:0]         wr_old, wr_new;
  logic [3:0]         wr_sum;
  logic [3:0]         cancel_id;
  logic [7:0]         add_price, cancel_price;

  function automatic logic [2:0] sat_qty(input logic [3:0] sum);
    return (sum > 4'(MAX_QTY)) ? 3'(MAX_QTY) : sum[2:0];
  endfunction

  function automatic logic [TOTAL_W-1:0] line_cost(input logic [7:0] price,
                                                   input logic [2:0] qty);
    logic [10:0] prod;
    prod = {3'b000, price} * {8'd0, qty};
    return TOTAL_W'(prod);
  endfunction

  // The IDLE accept edge already compares slot 0 against the incoming ID,
  // so SEARCH continues from slot 1 and each slot costs exactly one cycle.
  always_comb begin
    srch_idx = (state == ST_IDLE) ? '0 : idx;
    srch_id  = (state == ST_IDLE) ? Add_ProductID : add_id;
    at_end   = (srch_idx == count);
    hit      = !at_end && (slots[srch_idx[IDX_W-1:0]].id == srch_id);
    wr_slot  = idx[IDX_W-1:0];
    wr_old   = slots[wr_slot].qty;
    wr_sum   = {1'b0, wr_old} + {1'b0, add_qty};
    wr_new   = sat_qty(wr_sum);
    wr_sat   = (wr_sum > 4'(MAX_QTY));
    any_req  = Add_Req | Cancel_Req | Clear_Req;
    add_bad  = (Add_ProductID >= 4'(PRODUCT_COUNT)) || (Add_Quantity == 3'd0);
    cancel_id = slots[cursor].id;
  end

  product_price_rom add_rom    (.id(add_id),    .price(add_price));
  product_price_rom cancel_rom (.id(cancel_id), .price(cancel_price));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      count     <= '0;
      cursor    <= '0;
      total     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      add_id    <= '0;
      add_qty   <= '0;
      add_match <= 1'b0;
      idx       <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Clear_Req) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
            count    <= '0;
            cursor   <= '0;
            total    <= '0;
            done     <= 1'b1;
            err_code <= ERR_NONE;
          end else if (Cancel_Req) begin
            if (count == '0) begin
              error    <= 1'b1;
              err_code <= ERR_EMPTY;
            end else begin
              total <= total - line_cost(cancel_price, slots[cursor].qty);
              idx   <= {1'b0, cursor};
              busy  <= 1'b1;
              state <= ST_COMPACT;
            end
          end else if (Add_Req) begin
            if (add_bad) begin
              error    <= 1'b1;
              err_code <= ERR_BAD_ARG;
            end else begin
              add_id    <= Add_ProductID;
              add_qty   <= Add_Quantity;
              busy      <= 1'b1;
              add_match <= hit;
              if (at_end || hit) begin
                idx   <= '0;
                state <= ST_WRITE;
              end else begin
                idx   <= CNT_W'(1);
                state <= ST_SEARCH;
              end
            end
          end else if ((Cursor_Up ^ Cursor_Down) && (count != '0)) begin
            if (Cursor_Up)
              cursor <= (cursor == '0) ? IDX_W'(count - 1'b1) : cursor - 1'b1;
            else
              cursor <= ({1'b0, cursor} == count - 1'b1) ? '0 : cursor + 1'b1;
          end
        end

        ST_SEARCH: begin
          if (at_end) begin
            if (count == CNT_W'(NUM_SLOTS)) begin
              error    <= 1'b1;
              err_code <= ERR_FULL;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              add_match <= 1'b0;
              state     <= ST_WRITE;
            end
          end else if (hit) begin
            add_match <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // Merge charges only the quantity actually added after saturation.
        ST_WRITE: begin
          if (add_match) begin
            slots[wr_slot].qty <= wr_new;
            total    <= total + line_cost(add_price, wr_new - wr_old);
            error    <= wr_sat;
            err_code <= wr_sat ? ERR_QTY_SAT : ERR_NONE;
          end else begin
            slots[wr_slot] <= '{id: add_id, qty: add_qty};
            count    <= count + 1'b1;
            total    <= total + line_cost(add_price, add_qty);
            err_code <= ERR_NONE;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_COMPACT: begin
          if (idx == count - 1'b1) begin
            slots[wr_slot] <= '0;
            count <= count - 1'b1;
            if ({1'b0, cursor} >= count - 1'b1)
              cursor <= (count == CNT_W'(1)) ? '0 : IDX_W'(count - CNT_W'(2));
            done     <= 1'b1;
            err_code <= ERR_NONE;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            slots[wr_slot] <= slots[IDX_W'(idx + 1'b1)];
            idx <= idx + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      // A request landing on a busy controller is dropped but reported.
      if ((state != ST_IDLE) && any_req) begin
        error    <= 1'b1;
        err_code <= ERR_BUSY;
      end
    end
  end

  assign Read_ProductID = slots[Read_Index].id;
  assign Read_Quantity  = slots[Read_Index].qty;
  assign Read_Valid     = ({1'b0, Read_Index} < count);
  assign Busy           = busy;
  assign Done           = done;
  assign Error          = error;
  assign Error_Code     = err_code;
  assign Item_Count     = count;
  assign Cursor         = cursor;
  assign Total_Price    = total;

endmodule

// File: tb/tb_basket_controller.sv
// Directed bench for basket_controller with hand-computed expectations.
module tb_basket_controller;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Add_Req = 1'b0;
  logic [3:0]  Add_ProductID = '0;
  logic [2:0]  Add_Quantity = '0;
  logic        Cancel_Req = 1'b0;
  logic        Clear_Req = 1'b0;
  logic        Cursor_Up = 1'b0;
  logic        Cursor_Down = 1'b0;
  logic [2:0]  Read_Index = '0;
  logic [3:0]  Read_ProductID;
  logic [2:0]  Read_Quantity;
  logic        Read_Valid;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [2:0]  Error_Code;
  logic [3:0]  Item_Count;
  logic [2:0]  Cursor;
  logic [15:0] Total_Price;

  int checks = 0;
  int errors = 0;
  int lat;
  logic saw_done;

  basket_controller #(.NUM_SLOTS(8), .MAX_QTY(7), .TOTAL_W(16)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .Add_Req(Add_Req), .Add_ProductID(Add_ProductID), .Add_Quantity(Add_Quantity),
    .Cancel_Req(Cancel_Req), .Clear_Req(Clear_Req),
    .Cursor_Up(Cursor_Up), .Cursor_Down(Cursor_Down),
    .Read_Index(Read_Index), .Read_ProductID(Read_ProductID),
    .Read_Quantity(Read_Quantity), .Read_Valid(Read_Valid),
    .Busy(Busy), .Done(Done), .Error(Error), .Error_Code(Error_Code),
    .Item_Count(Item_Count), .Cursor(Cursor), .Total_Price(Total_Price)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] id, input logic [2:0] q);
    Add_ProductID = id;
    Add_Quantity  = q;
    Add_Req       = 1'b1;
    tick();
    Add_Req       = 1'b0;
  endtask

  task automatic cancel();
    Cancel_Req = 1'b1;
    tick();
    Cancel_Req = 1'b0;
  endtask

  task automatic clear();
    Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
  endtask

  task automatic move(input logic up, input logic down);
    Cursor_Up   = up;
    Cursor_Down = down;
    tick();
    Cursor_Up   = 1'b0;
    Cursor_Down = 1'b0;
  endtask

  // Called one cycle after the request edge; returns the T+n cycle of the response.
  task automatic wait_resp(output int n);
    n = 1;
    while (!(Done || Error) && n < 40) begin
      tick();
      n++;
    end
    if (!(Done || Error)) n = -1;
  endtask

  task automatic slot(input string tag, input int i, input logic [3:0] id, input logic [2:0] q);
    Read_Index = 3'(i);
    #1;
    check({tag, "_id"}, 32'(Read_ProductID), 32'(id));
    check({tag, "_qty"}, 32'(Read_Quantity), 32'(q));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_error", 32'(Error), 0);
    check("rst_code", 32'(Error_Code), 0);
    check("rst_count", 32'(Item_Count), 0);
    check("rst_total", 32'(Total_Price), 0);
    check("rst_valid", 32'(Read_Valid), 0);
    RESET_N = 1'b1;
    tick();

    // First add into empty basket: Done at T+2, total 2*55
    add(4'd3, 3'd2);
    check("add1_busy", 32'(Busy), 1);
    wait_resp(lat);
    check("add1_lat", lat, 2);
    check("add1_err", 32'(Error), 0);
    check("add1_count", 32'(Item_Count), 1);
    check("add1_total", 32'(Total_Price), 110);
    slot("add1_s0", 0, 4'd3, 3'd2);

    // Merge 2+4=6, then 6+4 saturates at 7 (delta 1)
    add(4'd3, 3'd4);
    wait_resp(lat);
    check("merge_lat", lat, 2);
    check("merge_total", 32'(Total_Price), 330);
    slot("merge_s0", 0, 4'd3, 3'd6);
    add(4'd3, 3'd4);
    wait_resp(lat);
    check("sat_lat", lat, 2);
    check("sat_done", 32'(Done), 1);
    check("sat_error", 32'(Error), 1);
    check("sat_code", 32'(Error_Code), 3);
    check("sat_total", 32'(Total_Price), 385);
    slot("sat_s0", 0, 4'd3, 3'd7);

    // Clear: immediate
    clear();
    check("clr_done", 32'(Done), 1);
    check("clr_count", 32'(Item_Count), 0);
    check("clr_total", 32'(Total_Price), 0);

    // Fill IDs 0..7 qty 1: append at k lands at T+k+2; total 377
    for (int k = 0; k < 8; k++) begin
      add(4'(k), 3'd1);
      wait_resp(lat);
      check("fill_lat", lat, k + 2);
    end
    check("fill_count", 32'(Item_Count), 8);
    check("fill_total", 32'(Total_Price), 377);

    add(4'd9, 3'd1);
    wait_resp(lat);
    check("full_lat", lat, 9);
    check("full_done", 32'(Done), 0);
    check("full_code", 32'(Error_Code), 1);
    check("full_count", 32'(Item_Count), 8);
    check("full_total", 32'(Total_Price), 377);

    // Match deep in the list: slot 5 -> Done at T+7, +30
    add(4'd5, 3'd1);
    wait_resp(lat);
    check("deep_lat", lat, 7);
    check("deep_code", 32'(Error_Code), 0);
    check("deep_total", 32'(Total_Price), 407);
    slot("deep_s5", 5, 4'd5, 3'd2);

    // Cancel with 4 entries at cursor 1: total 402 -> 352 at T+1, Done at T+4
    clear();
    add(4'd0, 3'd1); wait_resp(lat);
    add(4'd1, 3'd2); wait_resp(lat);
    add(4'd2, 3'd3); wait_resp(lat);
    add(4'd3, 3'd4); wait_resp(lat);
    check("c4_total", 32'(Total_Price), 402);
    move(1'b0, 1'b1);
    check("c4_cursor", 32'(Cursor), 1);
    cancel();
    check("c4_busy", 32'(Busy), 1);
    check("c4_total_early", 32'(Total_Price), 352);
    wait_resp(lat);
    check("c4_lat", lat, 4);
    check("c4_done", 32'(Done), 1);
    check("c4_count", 32'(Item_Count), 3);
    check("c4_cursor_after", 32'(Cursor), 1);
    slot("c4_s0", 0, 4'd0, 3'd1);
    slot("c4_s1", 1, 4'd2, 3'd3);
    slot("c4_s2", 2, 4'd3, 3'd4);
    Read_Index = 3'd3;
    #1;
    check("c4_s3_valid", 32'(Read_Valid), 0);
    check("c4_s3_zero", 32'(Read_ProductID), 0);
    tick();

    // Cancel the last entry at cursor 2: Done at T+2, cursor pulls back to 1
    move(1'b0, 1'b1);
    check("c3_cursor", 32'(Cursor), 2);
    cancel();
    wait_resp(lat);
    check("c3_lat", lat, 2);
    check("c3_count", 32'(Item_Count), 2);
    check("c3_cursor_after", 32'(Cursor), 1);
    check("c3_total", 32'(Total_Price), 132);

    // Empty cancel and bad argument
    clear();
    cancel();
    check("empty_error", 32'(Error), 1);
    check("empty_done", 32'(Done), 0);
    check("empty_code", 32'(Error_Code), 2);
    add(4'd12, 3'd1);
    check("badid_error", 32'(Error), 1);
    check("badid_code", 32'(Error_Code), 4);
    check("badid_count", 32'(Item_Count), 0);
    add(4'd1, 3'd0);
    check("badqty_code", 32'(Error_Code), 4);

    // Add during Busy: dropped with BUSY at T+2, original add completes at T+3
    add(4'd1, 3'd1); wait_resp(lat);
    add(4'd2, 3'd1);
    add(4'd6, 3'd1);
    check("busy_error", 32'(Error), 1);
    check("busy_done", 32'(Done), 0);
    check("busy_code", 32'(Error_Code), 5);
    tick();
    check("busy_orig_done", 32'(Done), 1);
    check("busy_orig_code", 32'(Error_Code), 0);
    check("busy_count", 32'(Item_Count), 2);
    check("busy_total", 32'(Total_Price), 65);

    // Cursor wrap with 3 entries
    add(4'd4, 3'd1); wait_resp(lat);
    check("wrap_count", 32'(Item_Count), 3);
    move(1'b1, 1'b0);
    check("wrap_up", 32'(Cursor), 2);
    move(1'b0, 1'b1);
    check("wrap_down", 32'(Cursor), 0);
    move(1'b1, 1'b1);
    check("wrap_both", 32'(Cursor), 0);

    // Reset in the middle of COMPACT aborts with no Done
    cancel();
    check("abort_busy_pre", 32'(Busy), 1);
    RESET_N = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 0);
    check("abort_count", 32'(Item_Count), 0);
    check("abort_total", 32'(Total_Price), 0);
    check("abort_code", 32'(Error_Code), 0);
    saw_done = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_done = saw_done | Done;
    end
    check("abort_no_done", 32'(saw_done), 0);
    check("abort_count_after", 32'(Item_Count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basket_controller.md
Name: basket_controller

Overview:
Downstream consumer of the shopping state machine. It holds the customer basket: up to NUM_SLOTS (product ID, quantity) entries.
- Add: merges a product into its existing entry or appends a new one.
- Cancel: removes the entry under the cursor and compacts the remaining entries.
- Totals: maintains a running total price.
- Display: exposes a combinational read port for the VGA/text display.

Parameters:
NUM_SLOTS, 8, basket depth (power of two, 2..16)
MAX_QTY, 7, per-entry quantity saturation limit (fits 3 bits)
TOTAL_W, 16, width of Total_Price

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
Add_Req  in  1  single-cycle pulse: add Add_Quantity of Add_ProductID
Add_ProductID  in  4  product ID, valid range 0..11
Add_Quantity  in  3  quantity to add, valid range 1..4
Cancel_Req  in  1  single-cycle pulse: remove the entry at Cursor
Clear_Req  in  1  single-cycle pulse: empty the basket
Cursor_Up  in  1  pulse: move cursor toward index 0
Cursor_Down  in  1  pulse: move cursor toward the last entry
Read_Index  in  log2(NUM_SLOTS)  display read address
Read_ProductID  out  4  combinational: ID at Read_Index
Read_Quantity  out  3  combinational: quantity at Read_Index
Read_Valid  out  1  combinational: Read_Index < Item_Count
Busy  out  1  operation in progress; requests not accepted
Done  out  1  one-cycle pulse: operation completed
Error  out  1  one-cycle pulse, coincident with or replacing Done
Error_Code  out  3  0 NONE, 1 FULL, 2 EMPTY, 3 QTY_SAT, 4 BAD_ARG, 5 BUSY; held until the next Done or Error
Item_Count  out  log2(NUM_SLOTS)+1  number of occupied entries
Cursor  out  log2(NUM_SLOTS)  highlighted entry
Total_Price  out  TOTAL_W  sum of price(ID)*qty over all entries

Behaviour:
Reset values:
- Entries occupy slots 0..Item_Count-1, contiguous.
- On reset: all outputs 0, all slots cleared, state IDLE.

States: IDLE, SEARCH, WRITE, COMPACT, DONE.

Request acceptance (in IDLE only):
- Priority: Clear > Cancel > Add.
- A request arriving while Busy=1 is dropped, with Error pulse and code BUSY.
- Request sampled at clock edge T; Busy=1 from T+1 until the cycle Done/Error pulses.

Add:
- BAD_ARG: ID>11 or qty=0. Error at T+1, no state change.
- SEARCH compares one slot per cycle, from index 0 to count-1.
- Match at slot j:
  - WRITE sets qty = min(qty+Add_Quantity, MAX_QTY).
  - Total_Price increases by price*(effective delta) only.
  - Done at T+j+2.
  - If saturated, Error pulses with QTY_SAT in the same cycle; the entry is still updated.
- No match, with k = Item_Count:
  - If k=NUM_SLOTS: Error FULL at T+k+1, no change.
  - Otherwise append at slot k, Item_Count increments, Total_Price increases by price*qty, Done at T+k+2.
  - Empty basket (k=0): insert, Done at T+2.

Cancel:
- Item_Count=0: Error EMPTY at T+1.
- Otherwise, with c = Cursor and k = Item_Count:
  - Total_Price decreases by price*qty of slot c at T+1.
  - COMPACT shifts slots c+1..k-1 down one slot per cycle (k-c-1 cycles).
  - The vacated top slot is zeroed, and Item_Count decrements.
  - Done at T+(k-c-1)+2.
  - After the cancel, if Cursor >= new count, Cursor = max(count-1, 0).

Clear:
- Item_Count, Cursor and Total_Price are zeroed at T+1.
- Done pulses at T+1.

Cursor:
- Moves only in IDLE with Item_Count>0.
- Wraps: Up at 0 goes to count-1; Down at count-1 goes to 0.
- Up and Down asserted in the same cycle: no move.
- Cursor pulses are ignored while Busy or while any request is accepted in that cycle (no error).

Arithmetic:
- Price product is 8 bits * 3 bits, zero-extended to TOTAL_W.
- Total cannot overflow: worst case 8*7*255 < 2^16.

Read port: purely combinational. Contents are stable except during WRITE/COMPACT edges.

Reset: RESET_N low mid-operation aborts immediately to the reset state. No Done is issued.

Decomposition:
Shared package basket_pkg holds:
- the Error_Code constants;
- the state encoding;
- PRODUCT_COUNT=12;
- the price table constants (8-bit price per product ID 0..11).
One sub-module: product_price_rom (combinational, 4-bit ID in, 8-bit price out; returns 0 for IDs above 11). The datapath uses two instances: one for add, one for cancel.

Test Plan:
- Reset, then Add(ID3,qty2) -> Done at T+2, Item_Count=1, slot0={3,2}, Total=2*price(3).
- Add(ID3,2), Add(ID3,4), Add(ID3,4) -> quantities 2, 6, then 7; third add gives Done+Error QTY_SAT, Total=7*price(3).
- Fill 8 distinct IDs, then Add(ID9,1) -> Error FULL at T+9, Item_Count stays 8, Total unchanged.
- 4 entries, Cursor=1, Cancel -> Done at T+4, slots shift {0,2,3}, Item_Count=3, Total reduced by the removed entry; then Cancel at Cursor=2 -> Cursor becomes 1.
- Cancel on empty -> Error EMPTY at T+1; Add(ID12,1) -> BAD_ARG; Add during Busy -> BUSY, original op completes normally.
- Cursor wrap: 3 entries, Up at 0 -> 2, Down at 2 -> 0; RESET_N low mid-COMPACT -> all outputs 0, no Done.
